// File: rtl/logic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_pkg
// Description : Op encoding shared by the logic unit and its combinational core.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'b000;
    localparam op_t OP_OR   = 3'b001;
    localparam op_t OP_NAND = 3'b010;
    localparam op_t OP_NOR  = 3'b011;
    localparam op_t OP_XOR  = 3'b100;
    localparam op_t OP_XNOR = 3'b101;
    localparam op_t OP_NOT  = 3'b110;
    localparam op_t OP_PASS = 3'b111;

endpackage
`default_nettype wire

// File: rtl/logic_core_nb.sv
`default_nettype none
// ============================================================================
// Module      : logic_core_nb
// Description : Combinational WIDTH-bit bitwise operator selected by op.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_core_nb
    import logic_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = a;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            OP_NOT:  res = ~a;
            OP_PASS: res = a;
            default: res = a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/logic_unit_nb.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_nb
// Description : Registered bitwise logic unit with accumulator chaining,
//               valid/ready handshake, result flags and completion counter.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_nb
    import logic_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [2:0]         op,
    input  logic               acc,
    input  logic               clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   o,
    output logic               zero,
    output logic               ones,
    output logic               parity,
    output logic [COUNT_W-1:0] done_cnt
);

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   o_q, o_d;
    logic               zero_q, zero_d;
    logic               ones_q, ones_d;
    logic               parity_q, parity_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] done_cnt_q, done_cnt_d;

    logic               accept;
    logic               out_hs;
    logic [WIDTH-1:0]   operand_b;
    logic [WIDTH-1:0]   result;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    // A clear in the same cycle makes the accumulator read as zero.
    assign operand_b = acc ? (clr ? '0 : acc_q) : y;

    logic_core_nb #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (x),
        .b   (operand_b),
        .op  (op),
        .res (result)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        o_d         = o_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        parity_d    = parity_q;
        acc_d       = acc_q;
        done_cnt_d  = done_cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            o_d         = result;
            zero_d      = (result == '0);
            ones_d      = (result == '1);
            parity_d    = ^result;
            acc_d       = result;
        end else begin
            if (out_hs) out_valid_d = 1'b0;
            if (clr)    acc_d       = '0;
        end

        if (clr)
            done_cnt_d = '0;
        else if (out_hs)
            done_cnt_d = done_cnt_q + COUNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            o_q         <= '0;
            zero_q      <= 1'b1;
            ones_q      <= 1'b0;
            parity_q    <= 1'b0;
            acc_q       <= '0;
            done_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            o_q         <= o_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            parity_q    <= parity_d;
            acc_q       <= acc_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign o         = o_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign parity    = parity_q;
    assign done_cnt  = done_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_nb.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_nb
// Description : Directed bench with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_nb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b1, acc = 1'b0, clr = 1'b0;
    logic [3:0] x = '0, y = '0;
    logic [2:0] op = '0;
    logic       in_ready, out_valid, zero, ones, parity;
    logic [3:0] o;
    logic [1:0] done_cnt;

    logic       in_valid8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0;
    logic [2:0] op8 = '0;
    logic       in_ready8, out_valid8, zero8, ones8, parity8;
    logic [7:0] o8;
    logic [7:0] done_cnt8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic_unit_nb #(.WIDTH(4), .COUNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op(op), .acc(acc), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready), .o(o),
        .zero(zero), .ones(ones), .parity(parity), .done_cnt(done_cnt)
    );

    logic_unit_nb #(.WIDTH(8), .COUNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .x(x8), .y(y8), .op(op8), .acc(1'b0), .clr(1'b0),
        .out_valid(out_valid8), .out_ready(1'b1), .o(o8),
        .zero(zero8), .ones(ones8), .parity(parity8), .done_cnt(done_cnt8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: truth-table semantics of each op on 4-bit values.
    function automatic logic [3:0] ref_op(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
        case (f)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return 4'hF ^ (a & b);
            3'd3: return 4'hF ^ (a | b);
            3'd4: return a ^ b;
            3'd5: return 4'hF ^ (a ^ b);
            3'd6: return 4'hF ^ a;
            default: return a;
        endcase
    endfunction

    // Model of the unit as a one-slot result buffer plus accumulator and counter.
    bit         m_full;
    logic [3:0] m_res, m_acc;
    int         m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full = 0; m_res = 0; m_acc = 0; m_done = 0;
        end else begin
            bit taken, delivered;
            logic [3:0] b;
            delivered = m_full && out_ready;
            taken     = in_valid && (!m_full || out_ready);
            b         = acc ? (clr ? 4'h0 : m_acc) : y;
            if (clr) m_done = 0;
            else if (delivered) m_done = (m_done + 1) % 4;
            if (taken) begin
                m_res = ref_op(op, x, b);
                m_acc = m_res;
                m_full = 1;
            end else begin
                if (delivered) m_full = 0;
                if (clr) m_acc = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model.out_valid", 32'(out_valid), 32'(m_full));
            check("model.in_ready", 32'(in_ready), 32'(!m_full || out_ready));
            check("model.o", 32'(o), 32'(m_res));
            check("model.zero", 32'(zero), 32'(m_res == 4'h0));
            check("model.ones", 32'(ones), 32'(m_res == 4'hF));
            check("model.parity", 32'(parity), 32'(^m_res));
            check("model.done_cnt", 32'(done_cnt), 32'(m_done));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b, input logic use_acc);
        in_valid = 1'b1; op = f; x = a; y = b; acc = use_acc;
    endtask

    initial begin
        #12;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.o", 32'(o), 32'h0);
        check("reset.zero", 32'(zero), 32'd1);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        step();

        // NAND sweep with one-cycle latency
        offer(3'b010, 4'h0, 4'h0, 1'b0); step();
        check("nand00.o", 32'(o), 32'hF);
        check("nand00.ones", 32'(ones), 32'd1);
        offer(3'b010, 4'h0, 4'h1, 1'b0); step();
        check("nand01.o", 32'(o), 32'hF);
        offer(3'b010, 4'h1, 4'h0, 1'b0); step();
        check("nand10.o", 32'(o), 32'hF);
        offer(3'b010, 4'h1, 4'h1, 1'b0); step();
        check("nand11.o", 32'(o), 32'hE);
        check("nand11.parity", 32'(parity), 32'd1);
        in_valid = 1'b0; step();

        // Backpressure
        out_ready = 1'b0;
        offer(3'b000, 4'hC, 4'hA, 1'b0); step();
        check("bp.o", 32'(o), 32'h8);
        check("bp.in_ready", 32'(in_ready), 32'd0);
        offer(3'b001, 4'h1, 4'h2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp.hold", 32'(o), 32'h8);
        end
        out_ready = 1'b1; step();
        check("bp.second", 32'(o), 32'h3);
        in_valid = 1'b0; step();
        check("bp.drained", 32'(out_valid), 32'd0);

        // Accumulate chain
        offer(3'b111, 4'hA, 4'h0, 1'b0); step();
        check("acc.pass", 32'(o), 32'hA);
        offer(3'b100, 4'hF, 4'h0, 1'b1); step();
        check("acc.xor", 32'(o), 32'h5);
        offer(3'b001, 4'h0, 4'hF, 1'b1); step();
        check("acc.readback", 32'(o), 32'h5);
        offer(3'b110, 4'h5, 4'h0, 1'b0); step();
        check("acc.not", 32'(o), 32'hA);
        check("acc.not.zero", 32'(zero), 32'd0);

        // Clear colliding with accumulate and output handshake
        offer(3'b111, 4'hC, 4'h0, 1'b0); step();
        clr = 1'b1;
        offer(3'b001, 4'h3, 4'h0, 1'b1); step();
        check("clr.o", 32'(o), 32'h3);
        check("clr.done_cnt", 32'(done_cnt), 32'd0);
        clr = 1'b0;
        offer(3'b001, 4'h0, 4'h0, 1'b1); step();
        check("clr.acc_b", 32'(o), 32'h3);
        check("clr.cnt_after", 32'(done_cnt), 32'd1);

        // Counter wrap at COUNT_W=2, plus the 8-bit instance
        clr = 1'b1;
        offer(3'b111, 4'h0, 4'h0, 1'b0); step();
        clr = 1'b0;
        in_valid8 = 1'b1; op8 = 3'b101; x8 = 8'hFF; y8 = 8'h00;
        step();
        in_valid8 = 1'b0;
        check("w8.o", 32'(o8), 32'h00);
        check("w8.zero", 32'(zero8), 32'd1);
        for (int i = 0; i < 4; i++) step();
        check("wrap.done_cnt", 32'(done_cnt), 32'd1);

        // Asynchronous reset mid-transaction
        out_ready = 1'b0;
        offer(3'b111, 4'h9, 4'h0, 1'b0); step();
        check("mid.out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.o", 32'(o), 32'h0);
        check("rst.zero", 32'(zero), 32'd1);
        check("rst.done_cnt", 32'(done_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst.in_ready", 32'(in_ready), 32'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_unit_nb.md
# logic_unit_nb

Parametrised, registered bitwise logic unit, successor to the fixed 4-bit gate cells. It selects one of eight bitwise operations per transaction and can chain operations through an internal accumulator. It accepts operands over a valid/ready handshake and presents a registered result with flags. It sits between the operand source and the result consumer in the datapath, replacing the per-gate 4-bit cells.

## Interface
- `WIDTH`, 4: operand/result width, ≥1
- `COUNT_W`, 8: width of completed-operation counter, ≥1

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: operand transaction offered
- `in_ready` out 1: unit can accept this cycle
- `x` in WIDTH: operand A
- `y` in WIDTH: operand B, ignored when `acc` = 1
- `op` in 3: operation select
- `acc` in 1: use accumulator as operand B
- `clr` in 1: synchronous clear of accumulator and counter
- `out_valid` out 1: result held in `o` is valid
- `out_ready` in 1: consumer takes the result
- `o` out WIDTH: registered result
- `zero` out 1: `o` == 0, registered with `o`
- `ones` out 1: `o` all ones, registered with `o`
- `parity` out 1: XOR-reduce of `o`, registered with `o`
- `done_cnt` out COUNT_W: count of completed output handshakes

## Operation
- Op encoding, with B = `acc` ? acc_q : `y`:
  - 000 AND
  - 001 OR
  - 010 NAND
  - 011 NOR
  - 100 XOR
  - 101 XNOR
  - 110 NOT x (B ignored)
  - 111 PASS x
- Accept = `in_valid` & `in_ready`.
- `in_ready` = !`out_valid` | `out_ready`. This is combinational and gives single-entry, full-throughput pipelining.
- On accept: `o`, `zero`, `ones`, `parity` load from the result, and `out_valid` is set to 1. acc_q loads the same result.
- Output handshake = `out_valid` & `out_ready`. On it, `done_cnt` increments, wrapping modulo 2^COUNT_W. `out_valid` clears unless a new accept happens in the same cycle.
- While `out_valid` = 1 and `out_ready` = 0, `o` and the flags hold and `in_ready` = 0.
- `clr`:
  - acc_q goes to 0 and `done_cnt` goes to 0 at the next edge.
  - Same cycle as an accept with `acc` = 1: operand B reads 0, and acc_q loads that result, so the accept wins over clear for acc_q.
  - Same cycle as an output handshake: `done_cnt` goes to 0, so clear wins over increment.
  - `clr` does not affect `o`, the flags or `out_valid`.
- Reset (asynchronous, at any time including mid-transaction): `out_valid` = 0, `o` = 0, `zero` = 1, `ones` = 0, `parity` = 0, acc_q = 0, `done_cnt` = 0. Any pending result is discarded. `in_ready` = 1 after reset.
- Widths: all logic is WIDTH-bit. There is no arithmetic except `done_cnt`, which wraps silently.

## Timing
- Latency: 1 cycle from accept edge to `out_valid` = 1 with the result.
- Throughput: 1 result per cycle when `out_ready` is held at 1.
- Back-to-back accumulate: the result of accept N is operand B of accept N+1 with no bubble.
- `in_ready` depends combinationally on `out_ready`. There is no other comb path from input to output.
- Reset deassertion is synchronised externally. The block only needs async assert behaviour.

## Structure
- Shared package `logic_pkg`: op encoding constants (`OP_AND` … `OP_PASS`) and the 3-bit op typedef.
- Sub-module `logic_core_nb`: purely combinational, parametrised by WIDTH. It takes x, B and op and produces the result.
- Top level holds the output register, flag registers, acc_q, counter and handshake logic.

## Test plan
- Reset: `rst_n` = 0 mid-stream with `out_valid` = 1 → immediately `out_valid` = 0, `o` = 0000, `zero` = 1, `done_cnt` = 0. After release, `in_ready` = 1.
- NAND sweep at WIDTH = 4, `op` = 010, `out_ready` = 1:
  - x = 0000, y = 0000 → `o` = 1111, `ones` = 1
  - x = 0000, y = 0001 → `o` = 1111
  - x = 0001, y = 0000 → `o` = 1111
  - x = 0001, y = 0001 → `o` = 1110, `parity` = 1
  - Each result appears one cycle after its accept.
- Backpressure: `out_ready` = 0, first accept of AND x = 1100, y = 1010 → `o` = 1000 and `in_ready` = 0. A second offer stalls, and `o` holds 1000 for 3 cycles. Raising `out_ready` completes both in order with no loss.
- Accumulate: PASS x = 1010 accepted, then XOR with `acc` = 1 and x = 1111 → `o` = 0101, acc_q = 0101. Then NOT x = 0101 → `o` = 1010, `zero` = 0.
- Clear collision: `clr` = 1 together with an accept of OR, `acc` = 1, x = 0011, while acc_q = 1100 → `o` = 0011, and the next accumulated op sees B = 0011. `done_cnt` reads 0 even with a simultaneous output handshake.
- Counter wrap: COUNT_W = 2, 5 output handshakes → `done_cnt` = 01. At WIDTH = 8, XNOR of x = 0xFF, y = 0x00 → `o` = 0x00, `zero` = 1.
